// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the pipelined Otter. This block holds the fetch
// PC and issues requests to a synchronous instruction memory that returns its
// data one cycle after the request. Returned words are buffered in a small
// FIFO, and decode drains them through a valid/ready handshake. A redirect
// from execute flushes the FIFO, drops any response still in flight, and
// restarts fetch at the new target.
//
// Parameters
//   RESET_PC     fetch address after reset
//   DEPTH        FIFO entries (power of 2, >= 2)
//
// Ports
//   CLK          in   1   sole clock, rising edge
//   RST          in   1   asynchronous, active-high reset
//   IMEM_REQ     out  1   fetch request; memory samples IMEM_ADDR when high
//   IMEM_ADDR    out  32  word-aligned fetch address
//   IMEM_DOUT    in   32  instruction word, valid one cycle after the request
//   IR_VALID     out  1   FIFO head is valid
//   IR_READY     in   1   decode accepts the head this cycle
//   IR           out  32  FIFO head instruction
//   IR_PC        out  32  PC of IR
//   OPCODE       out  7   IR[6:0]
//   FUNC3        out  3   IR[14:12]
//   FUNC7        out  1   IR[30]
//   REDIRECT     in   1   control-flow change from execute
//   REDIRECT_PC  in   32  new fetch target; bits [1:0] are forced to zero
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_DOUT,
    output logic        IR_VALID,
    input  logic        IR_READY,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    output logic [6:0]  OPCODE,
    output logic [2:0]  FUNC3,
    output logic        FUNC7,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q;
    logic [31:0] req_addr_q;
    logic [PW:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0] instr_q [DEPTH];
    logic [31:0] pc_q    [DEPTH];

    logic        push;
    logic        pop;
    logic [PW+1:0] occupancy;
    logic [31:0] redirect_target;

    // Masking keeps every REDIRECT_PC bit in use while forcing word alignment.
    assign redirect_target = REDIRECT_PC & ~32'h0000_0003;

    assign IR_VALID = (count_q != '0) && !REDIRECT;
    assign pop      = IR_VALID && IR_READY;
    assign push     = inflight_q && !REDIRECT;

    // Occupancy counts the buffered words and the word still in flight, less
    // the word leaving this cycle. Requesting only while it is below DEPTH
    // guarantees the FIFO never overflows. The path from IR_READY to
    // IMEM_REQ is combinational on purpose: it keeps one word per cycle
    // flowing with a two-entry FIFO.
    assign occupancy = {1'b0, count_q} + (PW+2)'(inflight_q) - (PW+2)'(pop);
    assign IMEM_REQ  = !RST && !REDIRECT && (occupancy < DEPTH_W);
    assign IMEM_ADDR = fetch_pc_q;

    assign IR     = instr_q[head_q];
    assign IR_PC  = pc_q[head_q];
    assign OPCODE = IR[6:0];
    assign FUNC3  = IR[14:12];
    assign FUNC7  = IR[30];

    // NOTE: every variable gets a default first, so no path through this
    // block leaves a value unassigned and no latch is inferred.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (REDIRECT) begin
            // A redirect overrides everything else in its cycle: the FIFO
            // empties and the pending response is dropped.
            fetch_pc_d = redirect_target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (IMEM_REQ) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: the FIFO storage is reset together with the control state, so IR
    // and IR_PC read zero out of reset rather than X.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= IMEM_REQ;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (IMEM_REQ) begin
                req_addr_q <= fetch_pc_q;
            end
            if (push) begin
                instr_q[tail_q] <= IMEM_DOUT;
                pc_q[tail_q]    <= req_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural one-cycle instruction memory
// answers requests. Expected {pc, instr} pairs are queued as each scenario is
// set up, and every accepted handshake pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_DOUT = '0;
    logic        IR_VALID;
    logic        IR_READY;
    logic [31:0] IR;
    logic [31:0] IR_PC;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNC3;
    logic        FUNC7;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_DOUT   (IMEM_DOUT),
        .IR_VALID    (IR_VALID),
        .IR_READY    (IR_READY),
        .IR          (IR),
        .IR_PC       (IR_PC),
        .OPCODE      (OPCODE),
        .FUNC3       (FUNC3),
        .FUNC7       (FUNC7),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h4000_5013 : a + 32'd1;
    endfunction

    // Synchronous instruction memory with one-cycle read latency.
    always @(posedge CLK) begin
        if (IMEM_REQ) IMEM_DOUT <= mem_word(IMEM_ADDR);
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int n_req    = 0;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [6:0]  obs_opcode;
    logic [2:0]  obs_func3;
    logic        obs_func7;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Samples outputs mid-cycle, scores any handshake, then advances to just
    // after the next rising edge, where the next inputs are driven.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        obs_req    = IMEM_REQ;
        obs_addr   = IMEM_ADDR;
        obs_valid  = IR_VALID;
        obs_pc     = IR_PC;
        obs_opcode = OPCODE;
        obs_func3  = FUNC3;
        obs_func7  = FUNC7;
        if (IMEM_REQ) n_req++;
        if (IR_VALID && IR_READY) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed IR_PC %h expected no handshake", IR_PC);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", IR_PC, e.pc);
                chk("sb_ir", IR, e.instr);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST         = 1'b1;
        IR_READY    = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = '0;

        // Reset state.
        tick();
        chk("rst_req",    32'(obs_req),    32'h0);
        chk("rst_valid",  32'(obs_valid),  32'h0);
        chk("rst_ir",     IR,              32'h0);
        chk("rst_ir_pc",  obs_pc,          32'h0);
        chk("rst_opcode", 32'(obs_opcode), 32'h0);
        chk("rst_func3",  32'(obs_func3),  32'h0);
        chk("rst_func7",  32'(obs_func7),  32'h0);
        tick();

        // Streaming with IR_READY high: one instruction per cycle.
        for (int i = 0; i < 8; i++) exp_push(32'(4 * i));
        IR_READY = 1'b1;
        RST      = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("s1_req",   32'(obs_req),   32'h1);
            chk("s1_addr",  obs_addr,       32'(4 * c));
            chk("s1_valid", 32'(obs_valid), (c >= 2) ? 32'h1 : 32'h0);
            if (c == 2) begin
                chk("s1_opcode", 32'(obs_opcode), 32'h13);
                chk("s1_func3",  32'(obs_func3),  32'h5);
                chk("s1_func7",  32'(obs_func7),  32'h1);
            end
        end
        chk("s1_drained", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset mid-cycle while a response is in flight.
        #2;
        RST = 1'b1;
        #1;
        chk("arst_valid", 32'(IR_VALID), 32'h0);
        chk("arst_req",   32'(IMEM_REQ), 32'h0);
        chk("arst_ir_pc", IR_PC,         32'h0);
        tick();

        // Stall: decode not ready for six cycles after reset release.
        IR_READY = 1'b0;
        RST      = 1'b0;
        n_req    = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c < 2) begin
                chk("s2_req",   32'(obs_req),   32'h1);
                chk("s2_addr",  obs_addr,       32'(4 * c));
                chk("s2_valid", 32'(obs_valid), 32'h0);
            end else begin
                chk("s2_hold_valid", 32'(obs_valid), 32'h1);
                chk("s2_hold_pc",    obs_pc,         32'h0);
            end
        end
        chk("s2_nreq",      32'(n_req), 32'h2);
        chk("s2_addr_hold", obs_addr,   32'h8);

        // Release: 0, 4, 8, ... with no gap, loss or duplicate.
        for (int i = 0; i < 5; i++) exp_push(32'(4 * i));
        IR_READY = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("s2_run_valid", 32'(obs_valid), 32'h1);
        end
        chk("s2_drained", 32'(exp_q.size()), 32'h0);

        // Redirect to 0x100 with the FIFO occupied and a word in flight.
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0100;
        tick();
        chk("r1_valid_pulse", 32'(obs_valid), 32'h0);
        chk("r1_req_pulse",   32'(obs_req),   32'h0);
        REDIRECT = 1'b0;
        tick();
        chk("r1_valid_t1", 32'(obs_valid), 32'h0);
        chk("r1_req_t1",   32'(obs_req),   32'h1);
        chk("r1_addr_t1",  obs_addr,       32'h0000_0100);
        tick();
        chk("r1_valid_t2", 32'(obs_valid), 32'h0);
        chk("r1_addr_t2",  obs_addr,       32'h0000_0104);
        exp_push(32'h0000_0100);
        exp_push(32'h0000_0104);
        tick();
        chk("r1_valid_t3", 32'(obs_valid), 32'h1);
        tick();
        chk("r1_drained", 32'(exp_q.size()), 32'h0);

        // Misaligned redirect target restarts at the aligned word.
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0103;
        tick();
        chk("r2_valid_pulse", 32'(obs_valid), 32'h0);
        REDIRECT = 1'b0;
        tick();
        chk("r2_addr", obs_addr, 32'h0000_0100);
        exp_push(32'h0000_0100);
        tick();
        tick();
        chk("r2_drained", 32'(exp_q.size()), 32'h0);

        // Redirect near the top of the address space: PC wraps to zero.
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'hFFFF_FFF8;
        tick();
        chk("r3_valid_pulse", 32'(obs_valid), 32'h0);
        REDIRECT = 1'b0;
        exp_push(32'hFFFF_FFF8);
        exp_push(32'hFFFF_FFFC);
        exp_push(32'h0000_0000);
        tick();
        chk("r3_addr0", obs_addr, 32'hFFFF_FFF8);
        tick();
        chk("r3_addr1", obs_addr, 32'hFFFF_FFFC);
        tick();
        chk("r3_addr2", obs_addr, 32'h0000_0000);
        tick();
        tick();
        chk("r3_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined Otter; the producer end of the instruction interface whose consumer is the control-unit decoder. It holds the fetch PC, issues requests to a 1-cycle-latency synchronous instruction memory, and buffers returned words in a small FIFO. It presents each word to decode with a valid/ready handshake, together with its PC and the pre-sliced OPCODE/FUNC3/FUNC7 fields. Branch/jump redirects flush the FIFO and discard any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset.
- DEPTH, 2: FIFO entries; must be a power of 2 and ≥ 2.

- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IMEM_REQ  out  1  fetch request; memory samples IMEM_ADDR when high.
- IMEM_ADDR  out  32  word-aligned fetch address.
- IMEM_DOUT  in  32  instruction word, valid exactly one cycle after the request cycle.
- IR_VALID  out  1  FIFO head is valid.
- IR_READY  in  1  decode accepts the head this cycle.
- IR  out  32  FIFO head instruction.
- IR_PC  out  32  PC of IR.
- OPCODE  out  7  IR[6:0].
- FUNC3  out  3  IR[14:12].
- FUNC7  out  1  IR[30].
- REDIRECT  in  1  control-flow change from execute.
- REDIRECT_PC  in  32  new fetch target; bits [1:0] are ignored and treated as 0.

## Operation
- State:
  - fetch_pc (32 bits).
  - inflight (1 bit): a request was issued last cycle.
  - FIFO: entries of {instr, pc}, head/tail pointers, count of width clog2(DEPTH)+1.
  - A registered copy of the request address, written into the FIFO alongside IMEM_DOUT.
- pop = IR_VALID & IR_READY.
- Issue rule: IMEM_REQ = !RST & !REDIRECT & (count + inflight − pop < DEPTH).
  - This is a combinational path from IR_READY to IMEM_REQ and is intentional.
  - The FIFO can never overflow.
- On issue: IMEM_ADDR = fetch_pc; fetch_pc ← fetch_pc + 4, modulo 2^32, so 0xFFFF_FFFC wraps to 0; inflight ← 1. Otherwise inflight ← 0.
- Response: when inflight = 1 and REDIRECT = 0, {IMEM_DOUT, request address} is pushed at the clock edge ending the response cycle.
- Pop: on pop, head advances. Simultaneous push and pop leaves count unchanged.
- Redirect has priority over every other event in its cycle:
  - FIFO is cleared.
  - The in-flight response is dropped, not pushed.
  - Pop is ignored.
  - fetch_pc ← {REDIRECT_PC[31:2], 2'b00}.
  - IR_VALID is forced to 0 combinationally in that cycle.
- IR_VALID = (count ≠ 0) & !REDIRECT.
- IR and IR_PC show the FIFO head. They are don't-care while IR_VALID = 0, but storage resets to 0.
- OPCODE, FUNC3 and FUNC7 are pure slices of IR.

## Timing
- Reset values:
  - fetch_pc = RESET_PC.
  - count = 0, inflight = 0, all FIFO storage = 0.
  - IMEM_REQ = 0, IR_VALID = 0, IR = 0, IR_PC = 0, OPCODE = 0, FUNC3 = 0, FUNC7 = 0.
- Asserting RST mid-operation clears all state immediately. Any response arriving after reset is discarded.
- Cycle 0 is the first cycle with RST low: IMEM_REQ = 1, IMEM_ADDR = RESET_PC. Cycle 1: data returns. Cycle 2: IR_VALID = 1.
- Request-to-IR_VALID latency is 2 cycles; redirect-to-IR_VALID latency is 3 cycles:
  - Redirect cycle t: no request.
  - t+1: request at the redirect target.
  - t+3: IR_VALID = 1.
- With IR_READY held high, the block sustains one instruction per cycle.
- Empty FIFO with inflight = 0 and no redirect: a request issues every cycle.
- Full FIFO with no pop: no request issues, and the head and IMEM_ADDR hold.

## Test plan
- Release reset, RESET_PC = 0, IR_READY = 1, memory returns 0x4000_5013 at address 0 and addr+1 elsewhere:
  - IMEM_ADDR sequence is 0, 4, 8, … from cycle 0.
  - IR_VALID rises at cycle 2 with IR_PC = 0, OPCODE = 7'b0010011, FUNC3 = 3'b101, FUNC7 = 1.
  - IR_PC then advances 4, 8, … with one instruction per cycle.
- Hold IR_READY = 0 from cycle 0 for 6 cycles:
  - Exactly 2 requests are issued (addresses 0 and 4).
  - IR_PC holds at 0.
  - After release, IR_PC runs 0, 4, 8 with no gap, loss or duplicate.
- With the FIFO full and a request in flight, pulse REDIRECT with REDIRECT_PC = 0x100:
  - IR_VALID = 0 during the pulse and the next 2 cycles.
  - The next IMEM_ADDR is 0x100.
  - The first valid IR_PC is 0x100, and no stale word appears.
- REDIRECT_PC = 0x103: fetch restarts at 0x100.
- REDIRECT_PC = 0xFFFF_FFF8: IR_PC sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Assert RST asynchronously mid-stream:
  - IR_VALID and IMEM_REQ drop within the same cycle.
  - After release, fetch resumes at RESET_PC.
  - The pre-reset in-flight word never appears on IR.
